ifetch_queue: RTL and testbench

- Instruction-fetch front end and the consumer side of the program-counter path.
- Owns the fetch address, reads a synchronous instruction memory, and buffers returned instructions with their PCs in a small FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes the queue and any in-flight read.

---
 rtl/ifetch_queue_pkg.sv | 15 +
 rtl/ifetch_queue_sync_fifo.sv | 65 ++++++
 rtl/ifetch_queue.sv | 88 ++++++++
 tb/tb_ifetch_queue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end: default widths,
// reset address, PC increment and the queued fetch entry layout.
package ifetch_queue_pkg;

  localparam int          AW_DEF       = 8;
  localparam int          IW_DEF       = 32;
  localparam logic [7:0]  RESET_PC_DEF = 8'h00;
  localparam int          PC_STEP      = 4;

  typedef struct packed {
    logic [AW_DEF-1:0] pc;
    logic [IW_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// Circular FIFO with synchronous flush; storage is not reset, only the
// pointers and occupancy count are.
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 40
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign push_ok = push_i && (count_q != CW'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i && !reset) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues synchronous memory
// reads and queues returned instructions with their PCs for decode.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          AW       = AW_DEF,
  parameter int          IW       = IW_DEF,
  parameter int          DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]    inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic [CW-1:0]    count;
  logic             fifo_push, fifo_pop, fifo_empty;
  logic [AW+IW-1:0] fifo_rdata;
  logic [OW-1:0]    occupancy;

  assign out_valid = !fifo_empty;
  // A pop coinciding with a redirect is voided: the head is discarded by the flush.
  assign fifo_pop  = out_valid && out_ready && !redirect_valid;
  assign fifo_push = inflight_q && !redirect_valid && !reset;

  // Slots committed after this cycle; the in-flight read holds a reserved slot.
  assign occupancy = OW'(count) + OW'(inflight_q) - OW'(fifo_pop);
  assign imem_req  = !reset && !redirect_valid && (occupancy < OW'(DEPTH));
  assign imem_addr = fetch_pc_q;

  assign out_pc    = fifo_empty ? '0 : fifo_rdata[AW+IW-1:IW];
  assign out_instr = fifo_empty ? '0 : fifo_rdata[IW-1:0];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = imem_req;
    if (imem_req) begin
      fetch_pc_d    = fetch_pc_q + AW'(PC_STEP);
      inflight_pc_d = fetch_pc_q;
    end
    if (redirect_valid) fetch_pc_d = {redirect_pc[AW-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + IW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({inflight_pc_q, imem_rdata}),
    .rdata_o (fifo_rdata),
    .count_o (count),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a bench-side PC model predicts every
// request and every delivered {pc, instr}; directed scenarios cover stall,
// redirect, wrap and mid-stream reset.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int         AW       = 8;
  localparam int         IW       = 32;
  localparam int         DEPTH    = 2;
  localparam logic [7:0] RESET_PC = 8'h00;

  logic          clk;
  logic          reset;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;

  int n_cmp = 0;
  int n_bad = 0;
  int req_cnt = 0;
  logic [7:0]   model_pc;
  fetch_entry_t sb[$];
  logic [7:0]   deliv[$];

  ifetch_queue #(
    .AW(AW), .IW(IW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {8'hC3, a, ~a, a ^ 8'h5A};
  endfunction

  // Synchronous memory: data for a request appears one cycle later.
  always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dv(input int i);
    return (i < deliv.size()) ? deliv[i] : 8'hxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin : monitor
    fetch_entry_t e;
    if (reset) begin
      check_val("req_in_reset", imem_req, 1'b0);
      sb.delete();
      model_pc = RESET_PC;
    end else if (redirect_valid) begin
      check_val("req_in_redirect", imem_req, 1'b0);
      sb.delete();
      model_pc = {redirect_pc[7:2], 2'b00};
    end else begin
      if (out_valid && out_ready) begin
        check_val("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_val("out_pc", out_pc, e.pc);
          check_val("out_instr", out_instr, e.instr);
          deliv.push_back(out_pc);
        end
      end
      if (!out_valid) begin
        check_val("empty_pc", out_pc, '0);
        check_val("empty_instr", out_instr, '0);
      end
      if (imem_req) begin
        check_val("imem_addr", imem_addr, model_pc);
        sb.push_back(fetch_entry_t'{pc: model_pc, instr: mem_word(model_pc)});
        model_pc = model_pc + 8'(PC_STEP);
        req_cnt++;
      end
      if (dut.fifo_push) check_val("no_overflow", dut.count == DEPTH, 1'b0);
    end
  end

  initial begin
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick(3);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_pc", out_pc, 8'h00);
    check_val("rst_out_instr", out_instr, 32'h0);
    check_val("rst_imem_req", imem_req, 1'b0);

    // Streaming from reset with decode always ready.
    reset = 1'b0; out_ready = 1'b1; deliv.delete();
    #1;
    check_val("t1_req_c0", imem_req, 1'b1);
    check_val("t1_addr_c0", imem_addr, 8'h00);
    check_val("t1_valid_c0", out_valid, 1'b0);
    tick(1);
    check_val("t1_valid_c1", out_valid, 1'b0);
    check_val("t1_addr_c1", imem_addr, 8'h04);
    tick(1);
    check_val("t1_valid_c2", out_valid, 1'b1);
    check_val("t1_pc_c2", out_pc, 8'h00);
    check_val("t1_addr_c2", imem_addr, 8'h08);
    tick(4);
    check_val("t1_ndeliv", deliv.size(), 4);
    check_val("t1_deliv3", dv(3), 8'h0C);

    // Decode stalled from reset: queue fills, requests stop.
    reset = 1'b1;
    tick(2);
    reset = 1'b0; out_ready = 1'b0; req_cnt = 0;
    tick(6);
    check_val("t2_req_cnt", req_cnt, 2);
    check_val("t2_full_valid", out_valid, 1'b1);
    check_val("t2_head_pc", out_pc, 8'h00);
    check_val("t2_req_stalled", imem_req, 1'b0);
    out_ready = 1'b1; deliv.delete();
    #1;
    check_val("t2_resume_req", imem_req, 1'b1);
    check_val("t2_resume_addr", imem_addr, 8'h08);
    tick(3);
    check_val("t2_deliv0", dv(0), 8'h00);
    check_val("t2_deliv1", dv(1), 8'h04);
    check_val("t2_deliv2", dv(2), 8'h08);

    // Redirect with the queue holding an entry and a read in flight.
    reset = 1'b1;
    tick(1);
    reset = 1'b0; out_ready = 1'b0;
    tick(2);
    redirect_valid = 1'b1; redirect_pc = 8'h43;
    #1;
    check_val("t3_req_redir", imem_req, 1'b0);
    tick(1);
    redirect_valid = 1'b0; out_ready = 1'b1; deliv.delete();
    #1;
    check_val("t3_req_after", imem_req, 1'b1);
    check_val("t3_addr_after", imem_addr, 8'h40);
    check_val("t3_valid_after", out_valid, 1'b0);
    tick(4);
    check_val("t3_deliv0", dv(0), 8'h40);
    check_val("t3_deliv1", dv(1), 8'h44);

    // Redirect while a valid head is being accepted: head must be dropped.
    check_val("t4_head_valid", out_valid, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 8'h80; deliv.delete();
    tick(1);
    redirect_valid = 1'b0;
    #1;
    check_val("t4_valid_next", out_valid, 1'b0);
    check_val("t4_no_deliv", deliv.size(), 0);
    tick(4);
    check_val("t4_deliv0", dv(0), 8'h80);

    // Address wrap at the top of the space.
    redirect_valid = 1'b1; redirect_pc = 8'hF8;
    tick(1);
    redirect_valid = 1'b0; deliv.delete();
    tick(8);
    check_val("t5_deliv0", dv(0), 8'hF8);
    check_val("t5_deliv1", dv(1), 8'hFC);
    check_val("t5_deliv2", dv(2), 8'h00);
    check_val("t5_deliv3", dv(3), 8'h04);

    // One-cycle reset in the middle of a stream.
    reset = 1'b1;
    tick(1);
    reset = 1'b0; deliv.delete();
    #1;
    check_val("t6_valid_after", out_valid, 1'b0);
    check_val("t6_req_after", imem_req, 1'b1);
    check_val("t6_addr_after", imem_addr, RESET_PC);
    tick(3);
    check_val("t6_deliv0", dv(0), RESET_PC);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
